// File: rtl/bpf_tone_detect.sv
// rtl/bpf_tone_detect.sv - rectify/average/hysteresis tone detector after the 40 kHz BPF
// Optional peak tracking is built when TONE_DET_PEAK_EN is defined.
module bpf_tone_detect #(
  parameter int WIN_LOG2 = 6,
  parameter int ON_CNT   = 3,
  parameter int OFF_CNT  = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        f_s,
  input  logic [15:0] din,
  input  logic [15:0] on_th,
  input  logic [15:0] off_th,
  output logic [15:0] level,
  output logic        level_vld,
  output logic        det,
  output logic        det_rise,
  output logic [15:0] peak
);

  localparam int AW = 15 + WIN_LOG2;

  typedef enum logic [1:0] {IDLE, ATTACK, DETECT, RELEASE} state_t;

  logic                s0, s1, evt;
  logic [15:0]         din_neg;
  logic [14:0]         a;
  logic [AW-1:0]       acc, acc_sum;
  logic [WIN_LOG2-1:0] cnt;
  logic                last;
  logic [15:0]         on_m, off_m;
  logic                above, below;

  state_t              state, state_n;
  logic [3:0]          acnt, acnt_n, rcnt, rcnt_n;
  logic                rise_n, det_n;

  // Synchronise the strobe and act on its rising edge only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s0 <= 1'b0;
      s1 <= 1'b0;
    end else begin
      s0 <= f_s;
      s1 <= s0;
    end
  end

  assign evt = s0 & ~s1 & en;

  // -32768 has no positive twin, so it saturates to 32767.
  always_comb begin
    din_neg = ~din + 16'd1;
    if (din == 16'h8000)
      a = 15'h7fff;
    else if (din[15])
      a = din_neg[14:0];
    else
      a = din[14:0];
  end

  assign acc_sum = acc + AW'(a);
  assign last    = (cnt == {WIN_LOG2{1'b1}});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc       <= '0;
      cnt       <= '0;
      level     <= '0;
      level_vld <= 1'b0;
    end else if (!en) begin
      acc       <= '0;
      cnt       <= '0;
      level_vld <= 1'b0;
    end else begin
      level_vld <= 1'b0;
      if (evt) begin
        if (last) begin
          level     <= 16'(acc_sum >> WIN_LOG2);
          level_vld <= 1'b1;
          acc       <= '0;
          cnt       <= '0;
        end else begin
          acc <= acc_sum;
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

`ifdef TONE_DET_PEAK_EN
  logic [14:0] run_max, max_n;

  assign max_n = (a > run_max) ? a : run_max;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_max <= '0;
      peak    <= '0;
    end else if (!en) begin
      run_max <= '0;
    end else if (evt) begin
      if (last) begin
        peak    <= {1'b0, max_n};
        run_max <= '0;
      end else begin
        run_max <= max_n;
      end
    end
  end
`else
  assign peak = '0;
`endif

  assign on_m  = on_th & 16'h7fff;
  assign off_m = off_th & 16'h7fff;
  assign above = (level >= on_m);
  assign below = (level < off_m);

  // Hysteresis FSM steps once per reported window, on the clk after level_vld.
  always_comb begin
    state_n = state;
    acnt_n  = acnt;
    rcnt_n  = rcnt;
    rise_n  = 1'b0;
    if (level_vld) begin
      case (state)
        IDLE, ATTACK: begin
          if (above) begin
            if (acnt + 4'd1 == 4'(ON_CNT)) begin
              state_n = DETECT;
              acnt_n  = 4'd0;
              rise_n  = 1'b1;
            end else begin
              state_n = ATTACK;
              acnt_n  = acnt + 4'd1;
            end
          end else begin
            state_n = IDLE;
            acnt_n  = 4'd0;
          end
        end
        DETECT, RELEASE: begin
          if (below) begin
            if (rcnt + 4'd1 == 4'(OFF_CNT)) begin
              state_n = IDLE;
              rcnt_n  = 4'd0;
            end else begin
              state_n = RELEASE;
              rcnt_n  = rcnt + 4'd1;
            end
          end else begin
            state_n = DETECT;
            rcnt_n  = 4'd0;
          end
        end
        default: state_n = IDLE;
      endcase
    end
    det_n = (state_n == DETECT) || (state_n == RELEASE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      acnt     <= '0;
      rcnt     <= '0;
      det      <= 1'b0;
      det_rise <= 1'b0;
    end else if (!en) begin
      state    <= IDLE;
      acnt     <= '0;
      rcnt     <= '0;
      det      <= 1'b0;
      det_rise <= 1'b0;
    end else begin
      state    <= state_n;
      acnt     <= acnt_n;
      rcnt     <= rcnt_n;
      det      <= det_n;
      det_rise <= rise_n;
    end
  end

endmodule
